uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a serial transmitter
// through a start/busy handshake with launch timeout.
module uart_tx_fifo #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int BUSY_TO = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          launch_err,
    input  logic          flag_clr,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy
);

    localparam int TW = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO);
    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] C_TO_LAST = TW'(BUSY_TO - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [AW:0]     w_count_nxt;
    logic            r_full;
    logic            r_empty;
    logic            r_overflow;
    logic            r_launch_err;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic [TW-1:0]   r_to_cnt;
    logic [TW-1:0]   w_to_cnt_nxt;
    logic            w_wr;
    logic            w_ovf;
    logic            w_pop;
    logic            w_to_err;

    assign full       = r_full;
    assign empty      = r_empty;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign launch_err = r_launch_err;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;

    // A write against a full FIFO is dropped even if a pop frees a slot
    assign w_wr  = wr_en & ~r_full;
    assign w_ovf = wr_en & r_full;

    // Handshake FSM: next state, pop request and timeout bookkeeping
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_to_err     = 1'b0;
        w_to_cnt_nxt = r_to_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (!r_empty && !tx_busy) begin
                    w_pop        = 1'b1;
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_to_cnt == C_TO_LAST) begin
                    w_to_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Occupancy: simultaneous write and pop leave the count unchanged
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // FSM state and launch timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    // Byte storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // Pointers, count and status derived from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Start pulse and held byte toward the transmitter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rptr];
            end
        end
    end

    // Sticky error flags; a new set beats a clear on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_launch_err <= 1'b0;
        end else begin
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end else if (flag_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_to_err) begin
                r_launch_err <= 1'b1;
            end else if (flag_clr) begin
                r_launch_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of the UART TX FIFO
// with a simple transmitter busy model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       launch_err;
    logic       flag_clr;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    logic       man_busy;
    logic       model_en;
    logic       mb;
    int         mcnt;
    int         busy_len;
    int         bad_starts;
    logic [7:0] rxq [$];

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_fifo #(.DEPTH(16), .AW(4), .BUSY_TO(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .launch_err (launch_err),
        .flag_clr   (flag_clr),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = model_en ? mb : man_busy;

    // Transmitter model: busy one cycle after a start, for busy_len cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !model_en) begin
            mb   <= 1'b0;
            mcnt <= 0;
        end else begin
            if (tx_start) begin
                rxq.push_back(tx_data);
                if (mb) bad_starts <= bad_starts + 1;
            end
            if (mb) begin
                if (mcnt == 1) mb <= 1'b0;
                mcnt <= mcnt - 1;
            end else if (tx_start) begin
                mb   <= 1'b1;
                mcnt <= busy_len;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int starts;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        flag_clr   = 1'b0;
        man_busy   = 1'b0;
        model_en   = 1'b0;
        busy_len   = 5;
        bad_starts = 0;

        // Reset state
        #22;
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_empty",  32'(empty), 32'd1);
        chk("rst_full",   32'(full), 32'd0);
        chk("rst_ovf",    32'(overflow), 32'd0);
        chk("rst_lerr",   32'(launch_err), 32'd0);
        chk("rst_start",  32'(tx_start), 32'd0);
        chk("rst_data",   32'(tx_data), 32'h00);
        rst_n = 1'b1;
        tick();

        // Single byte latency
        model_en = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("lat_cnt_N",   32'(count), 32'd1);
        chk("lat_start_N", 32'(tx_start), 32'd0);
        tick();
        chk("lat_start_N1", 32'(tx_start), 32'd1);
        chk("lat_data_N1",  32'(tx_data), 32'hA5);
        chk("lat_cnt_N1",   32'(count), 32'd0);
        tick();
        chk("lat_start_N2", 32'(tx_start), 32'd0);
        repeat (10) tick();
        chk("lat_hold",  32'(tx_data), 32'hA5);
        chk("lat_empty", 32'(empty), 32'd1);

        // Burst to full while busy, overflow, in-order drain
        model_en = 1'b0;
        man_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        chk("burst_full",  32'(full), 32'd1);
        chk("burst_count", 32'(count), 32'd16);
        chk("burst_start", 32'(tx_start), 32'd0);
        wr_data  = 8'h99;
        flag_clr = 1'b1;
        tick();
        wr_en    = 1'b0;
        flag_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_count",    32'(count), 32'd16);
        rxq.delete();
        busy_len = 3;
        model_en = 1'b1;
        guard = 0;
        while (rxq.size() < 16 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("drain_n", 32'(rxq.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i),
                (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD, 32'(i));
        end
        repeat (10) tick();
        chk("drain_empty", 32'(empty), 32'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Full FIFO: write and pop on the same edge, then launch timeout
        model_en = 1'b0;
        man_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h20 + i);
            tick();
        end
        chk("full2", 32'(full), 32'd1);
        wr_data  = 8'h77;
        man_busy = 1'b0;
        tick();
        wr_en = 1'b0;
        chk("pop_ovf",   32'(overflow), 32'd1);
        chk("pop_count", 32'(count), 32'd15);
        chk("pop_start", 32'(tx_start), 32'd1);
        chk("pop_data",  32'(tx_data), 32'h20);
        tick();
        chk("to_start_off", 32'(tx_start), 32'd0);
        chk("to_e1", 32'(launch_err), 32'd0);
        tick();
        tick();
        chk("to_e3", 32'(launch_err), 32'd0);
        tick();
        chk("to_e4", 32'(launch_err), 32'd1);
        tick();
        chk("to_idle_start", 32'(tx_start), 32'd1);
        chk("to_idle_data",  32'(tx_data), 32'h21);
        chk("to_idle_count", 32'(count), 32'd14);
        man_busy = 1'b1;
        tick();
        chk("to_sticky", 32'(launch_err), 32'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("lerr_clear", 32'(launch_err), 32'd0);
        chk("ovf_clear2", 32'(overflow), 32'd0);

        // Asynchronous reset in WAIT_DONE with bytes queued
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        chk("pre_rst_ovf", 32'(overflow), 32'd0);
        chk("pre_rst_cnt", 32'(count), 32'd15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full",  32'(full), 32'd0);
        chk("arst_data",  32'(tx_data), 32'h00);
        chk("arst_start", 32'(tx_start), 32'd0);
        man_busy = 1'b0;
        #1;
        rst_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tx_start) starts++;
        end
        chk("post_rst_starts", 32'(starts), 32'd0);
        chk("post_rst_empty",  32'(empty), 32'd1);

        // Forty bytes through pointer wrap with the busy model
        rxq.delete();
        bad_starts = 0;
        busy_len   = 20;
        model_en   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            guard = 0;
            while (full && guard < 2000) begin
                tick();
                guard++;
            end
            wr_en   = 1'b1;
            wr_data = 8'(8'h40 + i);
            tick();
            wr_en = 1'b0;
        end
        guard = 0;
        while (rxq.size() < 40 && guard < 5000) begin
            tick();
            guard++;
        end
        chk("wrap_n", 32'(rxq.size()), 32'd40);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("wrap_%0d", i),
                (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD, 32'(8'h40 + i));
        end
        chk("wrap_one_start", 32'(bad_starts), 32'd0);
        chk("wrap_ovf", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
